ram_march_bist: RTL and testbench
=================================

// Module: ram_march_bist
// PURPOSE
//   Synthesizable initiator for the single-port RAM: drives the RAM's write/read port through a fixed
//   four-phase pattern sweep and checks every read-back against the expected data.
//   Sits beside the RAM in place of the testbench driver. It gives a self-checking power-on or
//   on-demand memory test with a pass/fail summary that a host or the testbench polls.
// PARAMETERS
//   DATA_WIDTH  8      RAM data width
//   ADDR_WIDTH  4      RAM address width
//   DEPTH       16     words swept, addresses 0..DEPTH-1; must be <= 2**ADDR_WIDTH
//   SEED        8'hA5  pattern seed; truncated or zero-extended to DATA_WIDTH
//   ERR_W       8      width of error counter
// PORTS
//   clk        in   1           single clock, rising edge
//   rst_n      in   1           asynchronous active-low reset
//   start      in   1           run request, sampled only in IDLE
//   busy       out  1           high from WR0 through DRAIN
//   done       out  1           high in DONE; held until next accepted start
//   pass       out  1           valid when done=1; 1 = err_cnt==0
//   err_cnt    out  ERR_W       mismatch count, saturates at all-ones
//   fail_addr  out  ADDR_WIDTH  address of first mismatch of the run
//   ram_we     out  1           RAM write enable
//   ram_re     out  1           RAM read enable
//   ram_addr   out  ADDR_WIDTH  RAM address
//   ram_wdata  out  DATA_WIDTH  RAM write data
//   ram_rdata  in   DATA_WIDTH  RAM read data; valid exactly 1 cycle after ram_re
// BEHAVIOUR
//   Reset (async assert): all outputs 0, FSM=IDLE, addr counter 0, compare pipeline cleared.
//     ram_we/ram_re drop immediately, even mid-run. No partial result is retained.
//   PAT(a) = zero-extended(a) XOR SEED, taken over DATA_WIDTH bits.
//   FSM: IDLE -> WR0 -> RD0 -> WR1 -> RD1 -> DRAIN -> DONE -> (start) WR0.
//     IDLE/DONE: start=1 clears err_cnt, fail_addr and done; next cycle enters WR0 with addr=0.
//     WR0: ram_we=1, ram_wdata=PAT(addr), one address per cycle for DEPTH cycles.
//     RD0: ram_re=1, expected=PAT(addr), for DEPTH cycles.
//     WR1: ram_we=1, ram_wdata=~PAT(addr), for DEPTH cycles.
//     RD1: ram_re=1, expected=~PAT(addr), for DEPTH cycles.
//     DRAIN: 1 cycle, no RAM access; completes the final compare.
//   Address counter: increments every cycle in WR/RD states.
//     At addr==DEPTH-1 it wraps to 0 and the FSM advances to the next state.
//     Counter never exceeds DEPTH-1.
//   ram_we and ram_re are never high in the same cycle, and both are 0 in IDLE/DRAIN/DONE.
//   Compare pipeline: each read registers {valid, addr, expected}.
//     Next cycle compares against ram_rdata, independent of current FSM state.
//     So the last RD0 compare lands in the first WR1 cycle.
//   On mismatch:
//     err_cnt += 1, saturating at 2**ERR_W-1.
//     fail_addr is captured only if this is the first mismatch of the run.
//   busy is high for exactly 4*DEPTH+1 cycles. done and pass are registered on entry to DONE.
//   start is ignored while busy; a held start in DONE relaunches a run.
//   ram_addr, ram_wdata and ram_re are registered outputs. The RAM sees each access in the cycle after the FSM decision.
// TESTING
//   1. Ideal RAM model, SEED=A5, pulse start -> busy=1 for 65 cycles, then done=1, pass=1, err_cnt=0.
//   2. RAM bit0 stuck-at-0 at addr 5 -> RD0 clean (A0); RD1 expects 5F, gets 5E.
//      Required: err_cnt=1, fail_addr=5, pass=0.
//   3. RAM ram_rdata tied to 00 -> 32 mismatches.
//      Required: err_cnt=32, fail_addr=0, pass=0.
//   4. start pulsed during RD0 -> ignored; busy length unchanged, single done at the end.
//   5. rst_n low mid-WR1 -> ram_we=0 and busy/done/err_cnt=0 immediately.
//      Required: after release, start gives a full 65-cycle passing run.
//   6. Protocol checker over all runs: never ram_we&ram_re, ram_addr<DEPTH, every read compared exactly once.

Source files
------------

// File: rtl/ram_march_bist_if.sv
// ram_march_bist_if: single-port RAM access bus between the march BIST initiator (master) and the RAM (slave).
`default_nettype none

interface ram_march_bist_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  ram_we;
   logic                  ram_re;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;

   modport master (
      output ram_we,
      output ram_re,
      output ram_addr,
      output ram_wdata,
      input  ram_rdata
   );

   modport slave (
      input  ram_we,
      input  ram_re,
      input  ram_addr,
      input  ram_wdata,
      output ram_rdata
   );
endinterface

`default_nettype wire

// File: rtl/ram_march_bist.sv
// ram_march_bist: four-phase write/read/write-inverse/read-inverse RAM sweep with saturating error count.
`default_nettype none

module ram_march_bist #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 16,
   parameter     SEED       = 8'hA5,
   parameter int ERR_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_W-1:0]      err_cnt,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   ram_march_bist_if.master      ram
);

   localparam logic [DATA_WIDTH-1:0] C_SEED    = DATA_WIDTH'(SEED);
   localparam logic [ADDR_WIDTH-1:0] C_LAST    = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ERR_W-1:0]      C_ERR_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WR0   = 3'd1,
      S_RD0   = 3'd2,
      S_WR1   = 3'd3,
      S_RD1   = 3'd4,
      S_DRAIN = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a, input logic inv);
      logic [DATA_WIDTH-1:0] p;
      p = DATA_WIDTH'(a) ^ C_SEED;
      return inv ? ~p : p;
   endfunction

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  ram_we_q, ram_re_q;
   logic [DATA_WIDTH-1:0] ram_wdata_q;
   logic                  cmp_vld_q;
   logic [ADDR_WIDTH-1:0] cmp_addr_q;
   logic [DATA_WIDTH-1:0] cmp_exp_q;
   logic                  busy_q, done_q, pass_q;
   logic [ERR_W-1:0]      err_cnt_q, err_cnt_d;
   logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
   logic                  w_accept, w_mismatch, w_wr_d, w_rd_d, w_busy_d;

   assign w_accept   = start && (state_q == S_IDLE || state_q == S_DONE);
   assign w_mismatch = cmp_vld_q && (ram.ram_rdata != cmp_exp_q);
   assign w_wr_d     = (state_d == S_WR0) || (state_d == S_WR1);
   assign w_rd_d     = (state_d == S_RD0) || (state_d == S_RD1);
   assign w_busy_d   = w_wr_d || w_rd_d || (state_d == S_DRAIN);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_WR0;
               addr_d  = '0;
            end
         end
         S_WR0, S_RD0, S_WR1, S_RD1: begin
            if (addr_q == C_LAST) begin
               addr_d = '0;
               case (state_q)
                  S_WR0:   state_d = S_RD0;
                  S_RD0:   state_d = S_WR1;
                  S_WR1:   state_d = S_RD1;
                  default: state_d = S_DRAIN;
               endcase
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_DRAIN: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // The compare stage runs regardless of FSM state, so a read's result lands one cycle later.
   always_comb begin
      err_cnt_d   = err_cnt_q;
      fail_addr_d = fail_addr_q;
      if (w_accept) begin
         err_cnt_d   = '0;
         fail_addr_d = '0;
      end else if (w_mismatch) begin
         if (err_cnt_q == '0) begin
            fail_addr_d = cmp_addr_q;
         end
         if (err_cnt_q != C_ERR_MAX) begin
            err_cnt_d = err_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         ram_we_q    <= 1'b0;
         ram_re_q    <= 1'b0;
         ram_wdata_q <= '0;
         cmp_vld_q   <= 1'b0;
         cmp_addr_q  <= '0;
         cmp_exp_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_cnt_q   <= '0;
         fail_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         ram_we_q    <= w_wr_d;
         ram_re_q    <= w_rd_d;
         ram_wdata_q <= w_wr_d ? pat(addr_d, state_d == S_WR1) : '0;
         cmp_vld_q   <= ram_re_q;
         cmp_addr_q  <= addr_q;
         cmp_exp_q   <= pat(addr_q, state_q == S_RD1);
         busy_q      <= w_busy_d;
         done_q      <= (state_d == S_DONE);
         pass_q      <= (state_d == S_DONE) && (err_cnt_d == '0);
         err_cnt_q   <= err_cnt_d;
         fail_addr_q <= fail_addr_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_cnt       = err_cnt_q;
   assign fail_addr     = fail_addr_q;
   assign ram.ram_we    = ram_we_q;
   assign ram.ram_re    = ram_re_q;
   assign ram.ram_addr  = addr_q;
   assign ram.ram_wdata = ram_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_march_bist.sv
// tb_ram_march_bist: directed checks of the march BIST against a behavioural RAM with selectable faults.
`default_nettype none

module tb_ram_march_bist;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       busy, done, pass;
   logic [7:0] err_cnt;
   logic [3:0] fail_addr;
   int         mode;
   int         total;
   int         bad;
   int         blen;
   logic [7:0] mem [0:15];
   logic [7:0] rdata_q;

   ram_march_bist_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

   ram_march_bist #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .SEED(8'hA5), .ERR_W(8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_cnt   (err_cnt),
      .fail_addr (fail_addr),
      .ram       (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: mode 1 = bit0 stuck at 0 on address 5, mode 2 = read data tied to 0.
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_re) begin
         if (mode == 2)                             rdata_q <= 8'h00;
         else if (mode == 1 && bus.ram_addr == 4'd5) rdata_q <= mem[bus.ram_addr] & 8'hFE;
         else                                       rdata_q <= mem[bus.ram_addr];
      end
   end
   assign bus.ram_rdata = rdata_q;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("proto_we_re_excl", {31'd0, bus.ram_we & bus.ram_re}, 32'd0);
         chk("proto_addr_range", {31'd0, (bus.ram_addr > 4'd15)}, 32'd0);
      end
   end

   task automatic run(input int pulse_at, output int len);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("first_we",    {31'd0, bus.ram_we}, 32'd1);
      chk("first_addr",  {28'd0, bus.ram_addr}, 32'd0);
      chk("first_wdata", {24'd0, bus.ram_wdata}, 32'hA5);
      chk("start_clr_done", {31'd0, done}, 32'd0);
      chk("start_clr_err",  {24'd0, err_cnt}, 32'd0);
      len = 0;
      while (busy === 1'b1 && len < 200) begin
         len++;
         start = (len == pulse_at);
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      mode  = 0;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_pass", {31'd0, pass}, 32'd0);
      chk("rst_err",  {24'd0, err_cnt}, 32'd0);
      chk("rst_fail", {28'd0, fail_addr}, 32'd0);
      chk("rst_we_re", {30'd0, bus.ram_we, bus.ram_re}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Ideal RAM
      run(-1, blen);
      chk("t1_busy_len", blen, 32'd65);
      chk("t1_done", {31'd0, done}, 32'd1);
      chk("t1_pass", {31'd0, pass}, 32'd1);
      chk("t1_err",  {24'd0, err_cnt}, 32'd0);
      chk("t1_mem3",  {24'd0, mem[3]},  32'h59);
      chk("t1_mem15", {24'd0, mem[15]}, 32'h55);
      repeat (3) @(posedge clk);
      #1;
      chk("t1_done_held", {31'd0, done}, 32'd1);
      chk("t1_idle_we_re", {30'd0, bus.ram_we, bus.ram_re}, 32'd0);

      // Stuck bit at address 5: only the inverse read fails
      mode = 1;
      run(-1, blen);
      chk("t2_busy_len", blen, 32'd65);
      chk("t2_err",  {24'd0, err_cnt}, 32'd1);
      chk("t2_fail", {28'd0, fail_addr}, 32'd5);
      chk("t2_pass", {31'd0, pass}, 32'd0);
      chk("t2_done", {31'd0, done}, 32'd1);

      // Read data tied low: every read fails
      mode = 2;
      run(-1, blen);
      chk("t3_err",  {24'd0, err_cnt}, 32'd32);
      chk("t3_fail", {28'd0, fail_addr}, 32'd0);
      chk("t3_pass", {31'd0, pass}, 32'd0);

      // Start pulse during RD0 must be ignored
      mode = 0;
      run(20, blen);
      chk("t4_busy_len", blen, 32'd65);
      chk("t4_pass", {31'd0, pass}, 32'd1);
      chk("t4_err",  {24'd0, err_cnt}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("t4_no_rerun", {31'd0, busy}, 32'd0);
      chk("t4_done_held", {31'd0, done}, 32'd1);

      // Asynchronous reset in the middle of WR1
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (38) @(posedge clk);
      #1;
      chk("t5_in_wr1_we", {31'd0, bus.ram_we}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_we",   {31'd0, bus.ram_we}, 32'd0);
      chk("t5_rst_re",   {31'd0, bus.ram_re}, 32'd0);
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      chk("t5_rst_done", {31'd0, done}, 32'd0);
      chk("t5_rst_err",  {24'd0, err_cnt}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run(-1, blen);
      chk("t5_busy_len", blen, 32'd65);
      chk("t5_done", {31'd0, done}, 32'd1);
      chk("t5_pass", {31'd0, pass}, 32'd1);
      chk("t5_err",  {24'd0, err_cnt}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
